// File: rtl/regfile_wr_arbiter.sv
// Arbitrates ALU (A) and load-return (B) writebacks onto the single regfile write port; tracks pending loads for RAW stalls.
// Latency: a write accepted in cycle N drives rw/addr3/wdata in N+1. hazard is combinational from the pending scoreboard.
// Backpressure: one grant per cycle, B preferred, A forced through after STARVE_MAX stalled cycles; the loser sees ready=0.
module regfile_wr_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_addr,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic          hazard,
    output logic          rw,
    output logic [AW-1:0] addr3,
    output logic [DW-1:0] wdata
);

    localparam int NREG = 1 << AW;
    localparam int CW   = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic [CW-1:0]   starve_cnt;
    logic            starved;
    logic            grant_a;
    logic            grant_b;
    logic            granted;
    wr_t             win;
    logic            rw_q;
    logic            src_b_q;
    wr_t             out_q;
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    assign starved = a_valid && (starve_cnt == CW'(STARVE_MAX));

    // Grants are held off during reset so neither source believes it was accepted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            if (b_valid && !starved) begin
                grant_b = 1'b1;
            end else if (a_valid) begin
                grant_a = 1'b1;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign granted = grant_a || grant_b;

    always_comb begin
        win = '0;
        if (grant_b) begin
            win.addr = b_addr;
            win.data = b_data;
        end else begin
            win.addr = a_addr;
            win.data = a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!a_valid || grant_a) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // r0 writes are accepted but never reach the port; addr3/wdata keep the last real write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw_q    <= 1'b0;
            src_b_q <= 1'b0;
            out_q   <= '0;
        end else begin
            rw_q    <= granted && (win.addr != '0);
            src_b_q <= grant_b;
            if (granted && (win.addr != '0)) begin
                out_q <= win;
            end
        end
    end

    // A write sitting in the output stage when reset arrives must not commit that cycle.
    assign rw    = rw_q && rst_n;
    assign addr3 = out_q.addr;
    assign wdata = out_q.data;

    // Clear happens after the regfile has taken the value; a same-edge reissue wins.
    always_comb begin
        pend_nxt = pend;
        if (rw_q && src_b_q) begin
            pend_nxt[out_q.addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            pend_nxt[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign hazard = ((rs_addr != '0) && pend[rs_addr]) ||
                    ((rt_addr != '0) && pend[rt_addr]);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: committed writes are checked by a negedge monitor against a queue of expected writes.
// Combinational outputs (ready, hazard) are checked directly by the stimulus thread.
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SM = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, issue_valid;
    logic [AW-1:0] a_addr, b_addr, issue_addr, rs_addr, rt_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready, hazard, rw;
    logic [AW-1:0] addr3;
    logic [DW-1:0] wdata;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    regfile_wr_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .hazard(hazard),
        .rw(rw), .addr3(addr3), .wdata(wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every committed write must match the head of the queue.
    always @(negedge clk) begin
        if (rw === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got addr3=%0h wdata=%0h want none", addr3, wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_addr3", 64'(addr3), 64'(e.addr));
                chk("sb_wdata", 64'(wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        bit gb [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int ai = 0;
        int bi = 0;
        int ea = 0;
        int eb = 0;

        // 1: reset held two cycles with both requesters valid
        rst_n = 1'b0; issue_valid = 1'b0; issue_addr = '0; rs_addr = '0; rt_addr = '0;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_a_ready", 64'(a_ready), 64'd0);
            chk("rst_b_ready", 64'(b_ready), 64'd0);
            chk("rst_rw", 64'(rw), 64'd0);
            chk("rst_hazard", 64'(hazard), 64'd0);
        end
        step();
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("rst_addr3", 64'(addr3), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);

        // 2: only A
        step();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
        exp_q.push_back('{addr: 5'd5, data: 32'h1234});
        #1;
        chk("onlya_a_ready", 64'(a_ready), 64'd1);
        chk("onlya_b_ready", 64'(b_ready), 64'd0);
        step();
        a_valid = 1'b0;
        #1;
        chk("onlya_rw_n1", 64'(rw), 64'd1);
        chk("onlya_addr3_n1", 64'(addr3), 64'd5);
        step();
        #1;
        chk("onlya_rw_n2", 64'(rw), 64'd0);
        chk("onlya_addr3_hold", 64'(addr3), 64'd5);

        // 3: contention, expected grant order B,B,B,A,B,B,B,A
        for (int k = 0; k < 8; k++) begin
            if (gb[k]) begin
                exp_q.push_back('{addr: AW'(10 + eb), data: 32'hB000 + 32'(eb)});
                eb++;
            end else begin
                exp_q.push_back('{addr: AW'(20 + ea), data: 32'hA000 + 32'(ea)});
                ea++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            step();
            a_valid = 1'b1; a_addr = AW'(20 + ai); a_data = 32'hA000 + 32'(ai);
            b_valid = 1'b1; b_addr = AW'(10 + bi); b_data = 32'hB000 + 32'(bi);
            #1;
            chk($sformatf("arb%0d_a_ready", k), 64'(a_ready), 64'(!gb[k]));
            chk($sformatf("arb%0d_b_ready", k), 64'(b_ready), 64'(gb[k]));
            if (a_ready) ai++;
            if (b_ready) bi++;
        end
        step();
        a_valid = 1'b0; b_valid = 1'b0;

        // 4: scoreboard on r7, including same-edge reissue
        step();
        issue_valid = 1'b1; issue_addr = 5'd7; rs_addr = 5'd7; rt_addr = 5'd0;
        #1;
        chk("sb_hz_before_set", 64'(hazard), 64'd0);
        step();
        issue_valid = 1'b0;
        #1;
        chk("sb_hz_rs7", 64'(hazard), 64'd1);
        rs_addr = 5'd0; rt_addr = 5'd7;
        #1;
        chk("sb_hz_rt7", 64'(hazard), 64'd1);
        rs_addr = 5'd7; rt_addr = 5'd0;
        step();
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
        exp_q.push_back('{addr: 5'd7, data: 32'h77});
        #1;
        chk("sb_b7_ready", 64'(b_ready), 64'd1);
        chk("sb_hz_n", 64'(hazard), 64'd1);
        step();
        b_valid = 1'b0; issue_valid = 1'b1; issue_addr = 5'd7;
        #1;
        chk("sb_hz_n1", 64'(hazard), 64'd1);
        step();
        issue_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h88;
        exp_q.push_back('{addr: 5'd7, data: 32'h88});
        #1;
        chk("sb_hz_reissue", 64'(hazard), 64'd1);
        step();
        b_valid = 1'b0;
        #1;
        chk("sb_hz_n1_again", 64'(hazard), 64'd1);
        step();
        #1;
        chk("sb_hz_n2_clear", 64'(hazard), 64'd0);

        // A write to a pending register leaves it pending
        issue_valid = 1'b1; issue_addr = 5'd9;
        step();
        issue_valid = 1'b0; rs_addr = 5'd9;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
        exp_q.push_back('{addr: 5'd9, data: 32'h99});
        #1;
        chk("sb_hz_r9", 64'(hazard), 64'd1);
        step();
        a_valid = 1'b0;
        step();
        #1;
        chk("sb_hz_r9_after_a", 64'(hazard), 64'd1);

        // 5: register zero
        step();
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_addr = 5'd0;
        #1;
        chk("r0_b_ready", 64'(b_ready), 64'd1);
        step();
        b_valid = 1'b0; issue_valid = 1'b0; rs_addr = 5'd0;
        #1;
        chk("r0_rw", 64'(rw), 64'd0);
        chk("r0_hazard", 64'(hazard), 64'd0);
        chk("r0_addr3_hold", 64'(addr3), 64'd9);

        // 6: reset while a write sits in the output stage (r9 still pending)
        rs_addr = 5'd9;
        step();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h3333;
        #1;
        chk("mid_a_ready", 64'(a_ready), 64'd1);
        step();
        a_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("mid_rw_dropped", 64'(rw), 64'd0);
        step();
        #1;
        chk("mid_rw_after", 64'(rw), 64'd0);
        chk("mid_hazard_clear", 64'(hazard), 64'd0);
        chk("mid_addr3", 64'(addr3), 64'd0);
        rst_n = 1'b1;

        repeat (3) step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
